// File: rtl/dds_ctrl_set.sv
// Front-panel controller for the DDS generator: three debounced active-low keys
// step the waveform index and the saturating frequency tuning word.
// Optional auto-repeat of the frequency keys is enabled by defining LONG_PRESS_EN.
module dds_ctrl_set #(
  parameter int unsigned     N_WAVE   = 4,
  parameter int unsigned     WAVE_W   = 2,
  parameter int unsigned     FW_W     = 32,
  parameter logic [FW_W-1:0] F_INIT   = 32'd85899,
  parameter logic [FW_W-1:0] F_STEP   = 32'd85899,
  parameter logic [FW_W-1:0] F_MIN    = 32'd85899,
  parameter logic [FW_W-1:0] F_MAX    = 32'd858993459,
  parameter int unsigned     DEB_CYC  = 1000000
`ifdef LONG_PRESS_EN
  ,
  parameter int unsigned     LONG_CYC = 50000000,
  parameter int unsigned     REP_CYC  = 5000000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        key_in,
  output logic [WAVE_W-1:0] wave_sel,
  output logic [FW_W-1:0]   freq_word,
  output logic              cfg_valid,
  output logic [2:0]        key_state
);

  localparam int unsigned       CNT_W     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [WAVE_W-1:0] WAVE_LAST = WAVE_W'(N_WAVE - 1);

`ifdef LONG_PRESS_EN
  localparam int unsigned       LMAX      = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int unsigned       LCNT_W    = (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam logic [LCNT_W-1:0] LONG_LAST = LCNT_W'(LONG_CYC - 1);
  localparam logic [LCNT_W-1:0] REP_LAST  = LCNT_W'(REP_CYC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_DEB = 2'd1,
    S_HELD      = 2'd2,
    S_REL_DEB   = 2'd3
  } deb_state_e;

  // One press pulse per accepted key event, registered in the debouncer.
  logic [2:0] press;

  for (genvar g = 0; g < 3; g++) begin : g_key
    logic             sync0_q;
    logic             sync1_q;
    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             level_q;
`ifdef LONG_PRESS_EN
    localparam bit     REP_EN = (g != 0);
    logic [LCNT_W-1:0] lcnt_q;
    logic              rep_q;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        sync0_q <= 1'b1;
        sync1_q <= 1'b1;
        state_q <= S_IDLE;
        cnt_q   <= '0;
        press_q <= 1'b0;
        level_q <= 1'b1;
`ifdef LONG_PRESS_EN
        lcnt_q  <= '0;
        rep_q   <= 1'b0;
`endif
      end else begin
        sync0_q <= key_in[g];
        sync1_q <= sync0_q;
        press_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            if (!sync1_q) begin
              state_q <= S_PRESS_DEB;
              cnt_q   <= '0;
            end
          end
          S_PRESS_DEB: begin
            if (sync1_q) begin
              state_q <= S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= S_HELD;
              press_q <= 1'b1;
              level_q <= 1'b0;
`ifdef LONG_PRESS_EN
              lcnt_q  <= '0;
              rep_q   <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_HELD: begin
            if (sync1_q) begin
              state_q <= S_REL_DEB;
              cnt_q   <= '0;
            end
`ifdef LONG_PRESS_EN
            // First repeat after LONG_CYC cycles in HELD, then one every REP_CYC.
            else if (REP_EN) begin
              if (lcnt_q == (rep_q ? REP_LAST : LONG_LAST)) begin
                press_q <= 1'b1;
                lcnt_q  <= '0;
                rep_q   <= 1'b1;
              end else begin
                lcnt_q <= lcnt_q + 1'b1;
              end
            end
`endif
          end
          S_REL_DEB: begin
            if (!sync1_q) begin
              state_q <= S_HELD;
`ifdef LONG_PRESS_EN
              lcnt_q  <= '0;
              rep_q   <= 1'b0;
`endif
            end else if (cnt_q == CNT_LAST) begin
              state_q <= S_IDLE;
              level_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign press[g]     = press_q;
    assign key_state[g] = level_q;
  end

  logic [WAVE_W-1:0] wave_q, wave_d;
  logic [FW_W-1:0]   freq_q, freq_d;
  logic              cfg_q, cfg_d;

  // Saturation is tested on the distance to the bound, so no intermediate wraps.
  always_comb begin
    wave_d = wave_q;
    freq_d = freq_q;
    if (press[0]) begin
      wave_d = (wave_q == WAVE_LAST) ? '0 : wave_q + 1'b1;
    end
    if (press[1] && !press[2]) begin
      freq_d = ((F_MAX - freq_q) < F_STEP) ? F_MAX : freq_q + F_STEP;
    end else if (press[2] && !press[1]) begin
      freq_d = ((freq_q - F_MIN) < F_STEP) ? F_MIN : freq_q - F_STEP;
    end
    cfg_d = (wave_d != wave_q) || (freq_d != freq_q);
  end

  // cfg_valid is a bare one-cycle strobe with no ready: consumers must take it
  // on the cycle it is high, alongside the already-updated wave_sel/freq_word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wave_q <= '0;
      freq_q <= F_INIT;
      cfg_q  <= 1'b0;
    end else begin
      wave_q <= wave_d;
      freq_q <= freq_d;
      cfg_q  <= cfg_d;
    end
  end

  assign wave_sel  = wave_q;
  assign freq_word = freq_q;
  assign cfg_valid = cfg_q;

endmodule

// File: tb/tb_dds_ctrl_set.sv
// Directed bench for dds_ctrl_set: N_WAVE=3, DEB_CYC=4, small frequency bounds.
// Define LONG_PRESS_EN to also exercise the auto-repeat scenario.
module tb_dds_ctrl_set;

  localparam int unsigned N_WAVE  = 3;
  localparam int unsigned WAVE_W  = 2;
  localparam int unsigned FW_W    = 32;
  localparam int unsigned DEB_CYC = 4;
  localparam logic [31:0] F_INIT  = 32'd100;
  localparam logic [31:0] F_STEP  = 32'd40;
  localparam logic [31:0] F_MIN   = 32'd20;
  localparam logic [31:0] F_MAX   = 32'd200;
  localparam int          LAT     = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        key_in;
  logic [WAVE_W-1:0] wave_sel;
  logic [FW_W-1:0]   freq_word;
  logic              cfg_valid;
  logic [2:0]        key_state;

  dds_ctrl_set #(
    .N_WAVE  (N_WAVE),
    .WAVE_W  (WAVE_W),
    .FW_W    (FW_W),
    .F_INIT  (F_INIT),
    .F_STEP  (F_STEP),
    .F_MIN   (F_MIN),
    .F_MAX   (F_MAX),
    .DEB_CYC (DEB_CYC)
`ifdef LONG_PRESS_EN
    ,
    .LONG_CYC(20),
    .REP_CYC (5)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .wave_sel (wave_sel),
    .freq_word(freq_word),
    .cfg_valid(cfg_valid),
    .key_state(key_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // observations collected by the driver
  int                pulses;
  int                first_pulse;
  int                first_chg;
  int                pulse_q[$];
  logic [FW_W-1:0]   pfreq_q[$];
  logic [2:0]        held_ks;
  logic [2:0]        fin_ks;
  logic [WAVE_W-1:0] fin_wave;
  logic [FW_W-1:0]   fin_freq;

  // Caller is positioned 1 time unit after a rising edge. Keys in mask are held
  // low for `hold` sampling edges (c = 0 is the first), then released for `idle`.
  task automatic hold_key(input logic [2:0] mask, input int hold, input int idle);
    logic [WAVE_W-1:0] w0;
    logic [FW_W-1:0]   f0;
    pulses = 0;
    first_pulse = -1;
    first_chg = -1;
    pulse_q.delete();
    pfreq_q.delete();
    w0 = wave_sel;
    f0 = freq_word;
    key_in = ~mask;
    for (int c = 0; c < hold + idle; c++) begin
      if (c == hold) key_in = 3'b111;
      @(posedge clk);
      #1;
      if (cfg_valid === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
        pulse_q.push_back(c);
        pfreq_q.push_back(freq_word);
      end
      if (first_chg < 0 && (wave_sel !== w0 || freq_word !== f0)) first_chg = c;
      if (c == hold - 1) held_ks = key_state;
    end
    fin_ks   = key_state;
    fin_wave = wave_sel;
    fin_freq = freq_word;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (wave_sel !== 2'd0) begin n_fail++; $display("FAIL reset_wave got %0d want 0", wave_sel); end
    n_vec++; if (freq_word !== F_INIT) begin n_fail++; $display("FAIL reset_freq got %0d want %0d", freq_word, F_INIT); end
    n_vec++; if (key_state !== 3'b111) begin n_fail++; $display("FAIL reset_key_state got %b want 111", key_state); end
    n_vec++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid got %b want 0", cfg_valid); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (freq_word !== F_INIT || wave_sel !== 2'd0 || cfg_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset got w=%0d f=%0d v=%b want w=0 f=%0d v=0", wave_sel, freq_word, cfg_valid, F_INIT);
    end
  endtask

  task automatic test_wave_wrap();
    logic [WAVE_W-1:0] exp_w[5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 5; i++) begin
      hold_key(3'b001, 10, 12);
      n_vec++; if (fin_wave !== exp_w[i]) begin n_fail++; $display("FAIL wrap_wave[%0d] got %0d want %0d", i, fin_wave, exp_w[i]); end
      n_vec++; if (pulses != 1) begin n_fail++; $display("FAIL wrap_pulses[%0d] got %0d want 1", i, pulses); end
      n_vec++; if (first_pulse != LAT || first_chg != LAT) begin
        n_fail++; $display("FAIL wrap_latency[%0d] got pulse=%0d chg=%0d want %0d", i, first_pulse, first_chg, LAT);
      end
      n_vec++; if (held_ks !== 3'b110 || fin_ks !== 3'b111) begin
        n_fail++; $display("FAIL wrap_key_state[%0d] got held=%b rel=%b want 110/111", i, held_ks, fin_ks);
      end
      n_vec++; if (fin_freq !== F_INIT) begin n_fail++; $display("FAIL wrap_freq[%0d] got %0d want %0d", i, fin_freq, F_INIT); end
    end
  endtask

  task automatic test_bounce();
    hold_key(3'b001, 3, 1);
    n_vec++; if (pulses != 0 || first_chg != -1) begin n_fail++; $display("FAIL bounce_a got pulses=%0d chg=%0d want 0/-1", pulses, first_chg); end
    hold_key(3'b001, 3, 15);
    n_vec++; if (pulses != 0 || fin_wave !== 2'd2) begin n_fail++; $display("FAIL bounce_b got pulses=%0d w=%0d want 0/2", pulses, fin_wave); end
    n_vec++; if (fin_ks !== 3'b111) begin n_fail++; $display("FAIL bounce_key_state got %b want 111", fin_ks); end
    hold_key(3'b001, 10, 12);
    n_vec++; if (fin_wave !== 2'd0 || pulses != 1 || first_pulse != LAT) begin
      n_fail++; $display("FAIL bounce_clean got w=%0d pulses=%0d at=%0d want 0/1/%0d", fin_wave, pulses, first_pulse, LAT);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] up_f[4]   = '{32'd140, 32'd180, 32'd200, 32'd200};
    int          up_p[4]   = '{1, 1, 1, 0};
    logic [31:0] dn_f[6]   = '{32'd160, 32'd120, 32'd80, 32'd40, 32'd20, 32'd20};
    int          dn_p[6]   = '{1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      hold_key(3'b010, 10, 12);
      n_vec++; if (fin_freq !== up_f[i] || pulses != up_p[i]) begin
        n_fail++; $display("FAIL sat_up[%0d] got f=%0d pulses=%0d want f=%0d pulses=%0d", i, fin_freq, pulses, up_f[i], up_p[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      hold_key(3'b100, 10, 12);
      n_vec++; if (fin_freq !== dn_f[i] || pulses != dn_p[i]) begin
        n_fail++; $display("FAIL sat_dn[%0d] got f=%0d pulses=%0d want f=%0d pulses=%0d", i, fin_freq, pulses, dn_f[i], dn_p[i]);
      end
    end
    n_vec++; if (fin_wave !== 2'd0) begin n_fail++; $display("FAIL sat_wave got %0d want 0", fin_wave); end
  endtask

  task automatic test_simultaneous();
    hold_key(3'b111, 10, 12);
    n_vec++; if (fin_wave !== 2'd1 || fin_freq !== 32'd20) begin
      n_fail++; $display("FAIL simul_all got w=%0d f=%0d want 1/20", fin_wave, fin_freq);
    end
    n_vec++; if (pulses != 1 || first_pulse != LAT) begin n_fail++; $display("FAIL simul_all_pulse got %0d at %0d want 1 at %0d", pulses, first_pulse, LAT); end
    n_vec++; if (held_ks !== 3'b000) begin n_fail++; $display("FAIL simul_key_state got %b want 000", held_ks); end
    hold_key(3'b110, 10, 12);
    n_vec++; if (fin_freq !== 32'd20 || pulses != 0 || fin_wave !== 2'd1) begin
      n_fail++; $display("FAIL simul_updn got f=%0d w=%0d pulses=%0d want 20/1/0", fin_freq, fin_wave, pulses);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int p = 0;
    key_in = 3'b101;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    key_in = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (cfg_valid === 1'b1) p++;
    end
    n_vec++; if (p != 0 || freq_word !== F_INIT || wave_sel !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid_deb got pulses=%0d f=%0d w=%0d want 0/%0d/0", p, freq_word, wave_sel, F_INIT);
    end
    n_vec++; if (key_state !== 3'b111) begin n_fail++; $display("FAIL rst_mid_key_state got %b want 111", key_state); end
  endtask

  task automatic test_back_to_back();
    hold_key(3'b010, 8, 8);
    n_vec++; if (fin_freq !== 32'd140 || first_pulse != LAT) begin
      n_fail++; $display("FAIL b2b_up got f=%0d at=%0d want 140 at %0d", fin_freq, first_pulse, LAT);
    end
    hold_key(3'b100, 8, 8);
    n_vec++; if (fin_freq !== 32'd100 || first_pulse != LAT) begin
      n_fail++; $display("FAIL b2b_dn got f=%0d at=%0d want 100 at %0d", fin_freq, first_pulse, LAT);
    end
  endtask

`ifdef LONG_PRESS_EN
  task automatic test_long_press();
    int          exp_c[3] = '{7, 27, 32};
    logic [31:0] exp_f[3] = '{32'd140, 32'd180, 32'd200};
    hold_key(3'b010, 40, 12);
    n_vec++; if (pulses != 3 || fin_freq !== 32'd200) begin
      n_fail++; $display("FAIL long_key1 got pulses=%0d f=%0d want 3/200", pulses, fin_freq);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (i >= pulse_q.size() || pulse_q[i] != exp_c[i] || pfreq_q[i] !== exp_f[i]) begin
        n_fail++; $display("FAIL long_rep[%0d] got c=%0d f=%0d want c=%0d f=%0d", i, pulse_q[i], pfreq_q[i], exp_c[i], exp_f[i]);
      end
    end
    hold_key(3'b001, 40, 12);
    n_vec++; if (pulses != 1 || fin_wave !== 2'd1) begin
      n_fail++; $display("FAIL long_key0 got pulses=%0d w=%0d want 1/1", pulses, fin_wave);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    key_in = 3'b111;
    test_reset();
    test_wave_wrap();
    test_bounce();
    test_saturation();
    test_simultaneous();
    test_reset_mid_debounce();
    test_back_to_back();
`ifdef LONG_PRESS_EN
    test_long_press();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
